fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and runs a variable-latency request/ready handshake with instruction memory. It hands each fetched instruction and its PC to IF/ID through that register's enable and flush controls. It applies stalls from hazard detection and redirects from ID (branch/jump), and it discards any wrong-path memory response still in flight.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, runs the memory request/ready handshake, feeds IF/ID.
// Latency: hand-off is combinational with mem_ready_i, or the first unstalled cycle in HOLD.
// Backpressure: stall_i parks a received word in a hold buffer; redirects drop in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        enable_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] req_addr_q, req_addr_n;
    logic [31:0] hold_buf_q, hold_buf_n;

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        handoff;

    assign redirect   = jump_i | branch_i;
    assign target_raw = jump_i ? jump_target_i : branch_target_i;
    assign target     = {target_raw[31:2], 2'b00};
    assign pc_inc     = pc_q + 32'd4;

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_buf_q <= 32'd0;
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            req_addr_q <= req_addr_n;
            hold_buf_q <= hold_buf_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        req_addr_n = req_addr_q;
        hold_buf_n = hold_buf_q;
        handoff    = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_n = target;
                    if (mem_ready_i) begin
                        req_addr_n = target;
                    end else begin
                        // Request to the old path is still in flight; wait it out.
                        state_n = DISCARD;
                    end
                end else if (mem_ready_i && !stall_i) begin
                    handoff    = 1'b1;
                    pc_n       = pc_inc;
                    req_addr_n = pc_inc;
                end else if (mem_ready_i) begin
                    hold_buf_n = mem_data_i;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n       = target;
                    req_addr_n = target;
                    state_n    = FETCH;
                end else if (!stall_i) begin
                    handoff    = 1'b1;
                    pc_n       = pc_inc;
                    req_addr_n = pc_inc;
                    state_n    = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_n = target;
                end
                if (mem_ready_i) begin
                    req_addr_n = redirect ? target : pc_q;
                    state_n    = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign mem_req_o  = !rst_i && (state_q != HOLD);
    assign mem_addr_o = req_addr_q;
    assign pc_o       = pc_q;
    assign inst_o     = rst_i ? 32'd0 : ((state_q == HOLD) ? hold_buf_q : mem_data_i);
    assign enable_o   = handoff && !rst_i;
    assign flush_o    = redirect && !rst_i;

endmodule
